dem_merge_tree: RTL
===================

# dem_merge_tree

Pipelined recombination and self-check block for the DEM-DAC element-selection tree. It adds the LEAVES leaf values produced by a tree of switching stages, which is the inverse of the split (x = x_out1 + x_out2 at every node). It compares the result against the original tree input, delayed to align, and counts mismatches. It sits beside the switching tree as a run-time and bench monitor. The sum is swap-invariant, so no PN sequence is needed.

## Interface
- WIDTH, 16: signed width of each leaf value and of ref_i.
- LEAVES, 8: number of tree leaves; power of two, 2..16. L = log2(LEAVES).
- CNT_W, 16: width of the mismatch counter.
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- ref_i  in  WIDTH  signed value applied to the top of the switching tree this cycle.
- ref_valid_i  in  1  qualifies ref_i.
- leaf_i  in  LEAVES*WIDTH  signed leaf values; leaf j occupies bits [j*WIDTH +: WIDTH].
- clear_i  in  1  synchronous clear of err_cnt_o and err_sat_o.
- sum_o  out  WIDTH+L  signed reconstructed sum, full precision.
- sum_valid_o  out  1  sum_o, mismatch_o are valid.
- mismatch_o  out  1  sum differs from the aligned reference.
- err_cnt_o  out  CNT_W  saturating count of mismatches.
- err_sat_o  out  1  sticky; set when err_cnt_o reaches all-ones.

## Operation
- Upstream tree has L registered layers: leaves for ref at cycle t arrive on leaf_i at t+L.
- Reference path: ref_i and ref_valid_i enter a 2L-deep shift register, free-running every cycle.
- At stage L the shift register holds the reference matching the adder output.
- Adder tree: L registered layers.
  - Layer k adds adjacent pairs of layer k-1 into LEAVES/2^k values.
  - Operands are sign-extended; width grows by 1 bit per layer, so there is no overflow.
  - Layer 0 is leaf_i, unregistered.
- Compare stage (registered):
  - sum_o <= layer-L result.
  - sum_valid_o <= delayed ref_valid.
  - mismatch_o <= delayed ref_valid AND (layer-L result != sign-extended delayed ref).
- Counter update, on the same edge as the compare stage:
  - If clear_i: err_cnt_o <= 0 and err_sat_o <= 0. Clear wins over a simultaneous mismatch, which is not counted.
  - Else, if a mismatch is being registered and err_cnt_o != all-ones: err_cnt_o increments.
  - err_sat_o <= 1 when the new count is all-ones; it stays set until clear_i or reset.
- When sum_valid_o = 0: mismatch_o = 0. sum_o still carries the pipeline value and is don't-care for checking.

## Timing
- Reset state: every pipeline register, the ref shift register, sum_o, sum_valid_o, mismatch_o, err_cnt_o and err_sat_o are 0.
- Reset mid-operation flushes all in-flight references. After release, the first sum_valid_o comes only from a ref_valid_i sampled after release.
- Latency, leaf_i to sum_o: L+1 cycles.
- Latency, ref_valid_i to sum_valid_o / mismatch_o: 2L+1 cycles (7 for LEAVES=8).
- err_cnt_o and err_sat_o reflect a mismatch in the same cycle mismatch_o is high.
- Throughput is one sample per cycle. There is no backpressure or stall.
- Gaps in ref_valid_i produce matching gaps in sum_valid_o.

## Test plan
- Basic match, LEAVES=8:
  - Stimulus: ref_i=8, and 3 cycles later leaf_i all 1.
  - Required: 7 cycles after ref, sum_o=8, sum_valid_o=1, mismatch_o=0, err_cnt_o=0.
- Swap invariance and negative values:
  - Stimulus: ref_i=-3 with leaves {-1,-1,-1,0,0,0,0,0}, repeated with the leaves permuted.
  - Required: sum_o=-3, no mismatch on any permutation.
- Width growth:
  - Stimulus: all leaves 16'h7FFF, ref_i=16'h7FFF.
  - Required: sum_o=19'h3FFF8 and mismatch_o=1, err_cnt_o=1.
- Back-to-back stream:
  - Stimulus: 20 consecutive correct samples with one corrupted leaf on sample 10.
  - Required: exactly one mismatch_o pulse, at the 10th sum_valid_o; err_cnt_o=1.
- Saturation and clear, CNT_W=4:
  - Stimulus: 17 mismatches.
  - Required: err_cnt_o=15, err_sat_o=1 from the 15th mismatch.
  - Stimulus: clear_i together with a mismatch.
  - Required: err_cnt_o=0, err_sat_o=0.
- Reset mid-stream:
  - Stimulus: assert reset_i asynchronously with 5 samples in flight.
  - Required: all outputs 0 immediately, and no sum_valid_o until 7 cycles after the first new ref_valid_i.

Source files
------------

// File: rtl/dem_merge_tree_if.sv
// Bus bundle for dem_merge_tree: reference and leaf inputs from the switching tree,
// recombined sum, compare result and error counter back to the monitor side.
interface dem_merge_tree_if #(
    parameter int WIDTH  = 16,
    parameter int LEAVES = 8,
    parameter int CNT_W  = 16
);
    localparam int L = $clog2(LEAVES);

    logic signed [WIDTH-1:0]   ref_i;
    logic                      ref_valid_i;
    logic [LEAVES*WIDTH-1:0]   leaf_i;
    logic                      clear_i;
    logic signed [WIDTH+L-1:0] sum_o;
    logic                      sum_valid_o;
    logic                      mismatch_o;
    logic [CNT_W-1:0]          err_cnt_o;
    logic                      err_sat_o;

    modport master (
        output ref_i,
        output ref_valid_i,
        output leaf_i,
        output clear_i,
        input  sum_o,
        input  sum_valid_o,
        input  mismatch_o,
        input  err_cnt_o,
        input  err_sat_o
    );

    modport slave (
        input  ref_i,
        input  ref_valid_i,
        input  leaf_i,
        input  clear_i,
        output sum_o,
        output sum_valid_o,
        output mismatch_o,
        output err_cnt_o,
        output err_sat_o
    );
endinterface

// File: rtl/dem_merge_tree.sv
// Recombines the DEM switching-tree leaves with a pipelined adder tree, checks the
// sum against the delayed tree input and keeps a saturating mismatch count.
module dem_merge_tree #(
    parameter int WIDTH  = 16,
    parameter int LEAVES = 8,
    parameter int CNT_W  = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    dem_merge_tree_if.slave bus
);
    localparam int L     = $clog2(LEAVES);
    localparam int SW    = WIDTH + L;
    localparam int DEPTH = 2 * L;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // All tree nodes are carried at the final width; L extra bits can never overflow.
    function automatic logic signed [SW-1:0] sext_w(input logic [WIDTH-1:0] v);
        return {{L{v[WIDTH-1]}}, v};
    endfunction

    logic signed [SW-1:0]    src_s  [L][LEAVES];
    logic signed [SW-1:0]    node_q [L][LEAVES];
    logic signed [WIDTH-1:0] ref_sr_q [DEPTH];
    logic [DEPTH-1:0]        vld_sr_q;

    logic signed [SW-1:0]    root_s;
    logic signed [SW-1:0]    ref_ext_s;
    logic                    mismatch_d;
    logic [CNT_W-1:0]        err_cnt_d;
    logic                    err_sat_d;

    logic signed [SW-1:0]    sum_q;
    logic                    sum_valid_q;
    logic                    mismatch_q;
    logic [CNT_W-1:0]        err_cnt_q;
    logic                    err_sat_q;

    // Operand selection per layer: layer 0 reads the leaves, later layers the previous registers.
    always_comb begin
        for (int j = 0; j < LEAVES; j++) begin
            src_s[0][j] = sext_w(bus.leaf_i[j*WIDTH +: WIDTH]);
            for (int k = 1; k < L; k++) begin
                src_s[k][j] = node_q[k-1][j];
            end
        end
    end

    // Adder tree: register k holds the pairwise sums of layer k, halving the node count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < L; k++) begin
                for (int j = 0; j < LEAVES; j++) begin
                    node_q[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                for (int j = 0; j < LEAVES / 2; j++) begin
                    if (j < (LEAVES >> (k + 1))) begin
                        node_q[k][j] <= src_s[k][2*j] + src_s[k][2*j+1];
                    end
                end
            end
        end
    end

    // Reference delay line: L cycles of upstream tree plus L cycles of adder tree.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_sr_q[i] <= '0;
            end
            vld_sr_q <= '0;
        end else begin
            ref_sr_q[0] <= bus.ref_i;
            for (int i = 1; i < DEPTH; i++) begin
                ref_sr_q[i] <= ref_sr_q[i-1];
            end
            vld_sr_q <= {vld_sr_q[DEPTH-2:0], bus.ref_valid_i};
        end
    end

    // Compare and counter next-state; a clear in the same cycle suppresses the count.
    always_comb begin
        root_s     = node_q[L-1][0];
        ref_ext_s  = sext_w(ref_sr_q[DEPTH-1]);
        mismatch_d = vld_sr_q[DEPTH-1] & (root_s != ref_ext_s);
        err_cnt_d  = err_cnt_q;
        err_sat_d  = err_sat_q;
        if (bus.clear_i) begin
            err_cnt_d = '0;
            err_sat_d = 1'b0;
        end else if (mismatch_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1'b1);
            err_sat_d = err_sat_q | (err_cnt_d == CNT_MAX);
        end else begin
            err_cnt_d = err_cnt_q;
            err_sat_d = err_sat_q;
        end
    end

    // Output stage: sum, qualifier, compare flag and counter all change on the same edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_cnt_q   <= '0;
            err_sat_q   <= 1'b0;
        end else begin
            sum_q       <= root_s;
            sum_valid_q <= vld_sr_q[DEPTH-1];
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
            err_sat_q   <= err_sat_d;
        end
    end

    assign bus.sum_o       = sum_q;
    assign bus.sum_valid_o = sum_valid_q;
    assign bus.mismatch_o  = mismatch_q;
    assign bus.err_cnt_o   = err_cnt_q;
    assign bus.err_sat_o   = err_sat_q;

endmodule
